// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion and colour controller.
// A frame tick starts a fixed four-state update: X is computed, then Y, then the
// new position, direction and colour are committed together so the renderer
// only ever sees a consistent set of outputs, and only during vertical blank.
module sprite_motion_ctrl #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned SIZE       = 8,
   parameter int unsigned STEP       = 2,
   parameter int unsigned INIT_X     = 316,
   parameter int unsigned INIT_Y     = 236,
   parameter logic [2:0]  INIT_COLOR = 3'b111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       auto_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [2:0] collor,
   output logic       busy,
   output logic       edge_hit
);

   // Bounds and step in the 11-bit signed domain used for next-position math.
   localparam logic signed [10:0] XMaxS = 11'(H_ACTIVE - SIZE);
   localparam logic signed [10:0] YMaxS = 11'(V_ACTIVE - SIZE);
   localparam logic signed [10:0] StepS = 11'(STEP);

   typedef enum logic [1:0] {
      StIdle,
      StCalcX,
      StCalcY,
      StCommit
   } state_e;

   state_e state_q;

   // Inputs captured on the accepted tick; held stable for the whole update.
   logic auto_q;
   logic up_q;
   logic down_q;
   logic left_q;
   logic right_q;

   // Committed direction per axis: 0 = +1, 1 = -1.
   logic dir_x_q;
   logic dir_y_q;

   // Pending results, only made visible on commit.
   logic [9:0] nx_q;
   logic [9:0] ny_q;
   logic       ndir_x_q;
   logic       ndir_y_q;
   logic       hit_x_q;
   logic       hit_y_q;

   // Combinational per-axis results.
   logic signed [10:0] delta_x;
   logic signed [10:0] delta_y;
   logic signed [10:0] sum_x;
   logic signed [10:0] sum_y;
   logic [9:0]         calc_x;
   logic [9:0]         calc_y;
   logic               new_dir_x;
   logic               new_dir_y;
   logic               hit_x;
   logic               hit_y;
   logic [2:0]         next_color;

   // X axis: pick the displacement, add in signed form, clamp, then truncate.
   always_comb begin
      delta_x   = '0;
      calc_x    = '0;
      new_dir_x = dir_x_q;
      hit_x     = 1'b0;
      if (auto_q) begin
         delta_x = dir_x_q ? -StepS : StepS;
      end else if (right_q && !left_q) begin
         delta_x = StepS;
      end else if (left_q && !right_q) begin
         delta_x = -StepS;
      end
      sum_x = $signed({1'b0, pos_x}) + delta_x;
      if (sum_x > XMaxS) begin
         calc_x = XMaxS[9:0];
         if (auto_q) begin
            new_dir_x = 1'b1;
            hit_x     = 1'b1;
         end
      end else if (sum_x[10]) begin
         calc_x = '0;
         if (auto_q) begin
            new_dir_x = 1'b0;
            hit_x     = 1'b1;
         end
      end else begin
         calc_x = sum_x[9:0];
      end
   end

   // Y axis: same scheme as X with up as the negative direction.
   always_comb begin
      delta_y   = '0;
      calc_y    = '0;
      new_dir_y = dir_y_q;
      hit_y     = 1'b0;
      if (auto_q) begin
         delta_y = dir_y_q ? -StepS : StepS;
      end else if (down_q && !up_q) begin
         delta_y = StepS;
      end else if (up_q && !down_q) begin
         delta_y = -StepS;
      end
      sum_y = $signed({1'b0, pos_y}) + delta_y;
      if (sum_y > YMaxS) begin
         calc_y = YMaxS[9:0];
         if (auto_q) begin
            new_dir_y = 1'b1;
            hit_y     = 1'b1;
         end
      end else if (sum_y[10]) begin
         calc_y = '0;
         if (auto_q) begin
            new_dir_y = 1'b0;
            hit_y     = 1'b1;
         end
      end else begin
         calc_y = sum_y[9:0];
      end
   end

   // Colour step: cycles 001..111 and never lands on black.
   always_comb begin
      next_color = collor + 3'd1;
      if (collor == 3'b111) begin
         next_color = 3'b001;
      end
   end

   // Update sequencer with registered outputs; ticks outside idle are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         auto_q   <= 1'b0;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         dir_x_q  <= 1'b0;
         dir_y_q  <= 1'b0;
         nx_q     <= '0;
         ny_q     <= '0;
         ndir_x_q <= 1'b0;
         ndir_y_q <= 1'b0;
         hit_x_q  <= 1'b0;
         hit_y_q  <= 1'b0;
         pos_x    <= 10'(INIT_X);
         pos_y    <= 10'(INIT_Y);
         collor   <= INIT_COLOR;
         busy     <= 1'b0;
         edge_hit <= 1'b0;
      end else begin
         edge_hit <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (frame_tick) begin
                  auto_q  <= auto_mode;
                  up_q    <= btn_up;
                  down_q  <= btn_down;
                  left_q  <= btn_left;
                  right_q <= btn_right;
                  busy    <= 1'b1;
                  state_q <= StCalcX;
               end
            end
            StCalcX: begin
               nx_q     <= calc_x;
               ndir_x_q <= new_dir_x;
               hit_x_q  <= hit_x;
               state_q  <= StCalcY;
            end
            StCalcY: begin
               ny_q     <= calc_y;
               ndir_y_q <= new_dir_y;
               hit_y_q  <= hit_y;
               state_q  <= StCommit;
            end
            StCommit: begin
               pos_x   <= nx_q;
               pos_y   <= ny_q;
               dir_x_q <= ndir_x_q;
               dir_y_q <= ndir_y_q;
               // A corner counts once: one pulse, one colour step.
               if (hit_x_q || hit_y_q) begin
                  edge_hit <= 1'b1;
                  collor   <= next_color;
               end
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl. Three instances share all inputs:
// a uses default reset position, b starts next to the bottom-right corner,
// c starts next to the right edge and one pixel below the top edge.
module tb_sprite_motion_ctrl;

   logic clk;
   logic rst_n;
   logic frame_tick;
   logic auto_mode;
   logic btn_up;
   logic btn_down;
   logic btn_left;
   logic btn_right;

   logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic [2:0] a_col, b_col, c_col;
   logic       a_busy, b_busy, c_busy;
   logic       a_hit, b_hit, c_hit;

   int checks;
   int errors;

   sprite_motion_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_mode(auto_mode),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .pos_x(a_x), .pos_y(a_y), .collor(a_col), .busy(a_busy), .edge_hit(a_hit)
   );

   sprite_motion_ctrl #(.INIT_X(631), .INIT_Y(471)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_mode(auto_mode),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .pos_x(b_x), .pos_y(b_y), .collor(b_col), .busy(b_busy), .edge_hit(b_hit)
   );

   sprite_motion_ctrl #(.INIT_X(631), .INIT_Y(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_mode(auto_mode),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .pos_x(c_x), .pos_y(c_y), .collor(c_col), .busy(c_busy), .edge_hit(c_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse frame_tick for one cycle; returns just after the sampling edge.
   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   // From just after the tick edge, three more edges reach the committed state.
   task automatic wait_commit();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      auto_mode  = 1'b0;
      btn_up     = 1'b0;
      btn_down   = 1'b0;
      btn_left   = 1'b0;
      btn_right  = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_a_x", a_x, 316);
      check("rst_a_y", a_y, 236);
      check("rst_a_col", a_col, 3'b111);
      check("rst_a_busy", a_busy, 0);
      check("rst_a_hit", a_hit, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_a_x", a_x, 316);
      check("idle_a_y", a_y, 236);
      check("idle_a_busy", a_busy, 0);

      // Manual right: busy for three cycles, position lands on the commit edge
      btn_right = 1'b1;
      tick();
      check("m1_busy1", a_busy, 1);
      check("m1_x_early", a_x, 316);
      @(negedge clk);
      check("m1_busy2", a_busy, 1);
      @(negedge clk);
      check("m1_busy3", a_busy, 1);
      check("m1_x_late", a_x, 316);
      @(negedge clk);
      check("m1_busy_done", a_busy, 0);
      check("m1_a_x", a_x, 318);
      check("m1_a_y", a_y, 236);
      check("m1_a_hit", a_hit, 0);
      check("m1_a_col", a_col, 3'b111);
      check("m1_c_x_clamp", c_x, 632);
      check("m1_c_hit", c_hit, 0);

      // Held right at the bound stays clamped
      tick();
      wait_commit();
      check("m2_c_x", c_x, 632);
      check("m2_a_x", a_x, 320);

      // Manual up clamps at zero
      btn_right = 1'b0;
      btn_up    = 1'b1;
      tick();
      wait_commit();
      check("m3_c_y", c_y, 0);
      check("m3_a_y", a_y, 234);
      check("m3_c_col", c_col, 3'b111);

      // Opposing buttons cancel
      btn_up    = 1'b0;
      btn_left  = 1'b1;
      btn_right = 1'b1;
      tick();
      wait_commit();
      check("m4_a_x", a_x, 320);
      check("m4_a_y", a_y, 234);

      // Mode change during an update only applies to the next tick
      btn_left = 1'b0;
      tick();
      auto_mode = 1'b1;
      wait_commit();
      check("ms_a_x", a_x, 322);
      check("ms_a_y", a_y, 234);
      check("ms_a_hit", a_hit, 0);

      // Auto mode from a fresh reset
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      btn_right = 1'b0;
      auto_mode = 1'b1;
      tick();
      wait_commit();
      check("a1_c_x", c_x, 632);
      check("a1_c_y", c_y, 3);
      check("a1_c_hit", c_hit, 1);
      check("a1_c_col", c_col, 3'b001);
      check("a1_b_x", b_x, 632);
      check("a1_b_y", b_y, 472);
      check("a1_b_hit", b_hit, 1);
      check("a1_b_col", b_col, 3'b001);
      check("a1_a_x", a_x, 318);
      check("a1_a_y", a_y, 238);
      check("a1_a_hit", a_hit, 0);
      check("a1_a_col", a_col, 3'b111);
      @(negedge clk);
      check("a1_c_hit_end", c_hit, 0);
      check("a1_b_hit_end", b_hit, 0);
      check("a1_b_col_hold", b_col, 3'b001);

      // Bounced direction carries into the next frame
      tick();
      wait_commit();
      check("a2_c_x", c_x, 630);
      check("a2_c_y", c_y, 5);
      check("a2_c_hit", c_hit, 0);
      check("a2_c_col", c_col, 3'b001);
      check("a2_b_x", b_x, 630);
      check("a2_b_y", b_y, 470);
      check("a2_b_hit", b_hit, 0);
      check("a2_a_x", a_x, 320);

      // Tick held for two cycles: the second is ignored while busy
      auto_mode = 1'b0;
      btn_right = 1'b1;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk);
      @(negedge clk) frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      check("dt_a_x", a_x, 322);
      check("dt_a_busy", a_busy, 0);
      repeat (4) @(negedge clk);
      check("dt_a_x_hold", a_x, 322);
      check("dt_a_busy_hold", a_busy, 0);

      // Reset mid-update discards the pending result
      tick();
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rm_a_x", a_x, 316);
      check("rm_a_y", a_y, 236);
      check("rm_a_col", a_col, 3'b111);
      check("rm_a_busy", a_busy, 0);
      check("rm_c_y", c_y, 1);
      @(negedge clk) rst_n = 1'b1;
      btn_right = 1'b0;
      repeat (5) @(negedge clk);
      check("rm_a_x_after", a_x, 316);
      check("rm_a_busy_after", a_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
